// File: rtl/encoder_pkg.sv
// Shared widths, saturation limits and quadrature state encoding for the encoder RPM meter.
package encoder_pkg;

   localparam int DELTA_W = 20;
   localparam int RPM_W   = 16;
   localparam int PROD_W  = 36;

   localparam logic signed [DELTA_W-1:0] DELTA_MAX = {1'b0, {(DELTA_W-1){1'b1}}};
   localparam logic signed [DELTA_W-1:0] DELTA_MIN = {1'b1, {(DELTA_W-1){1'b0}}};
   localparam logic signed [RPM_W-1:0]   RPM_MAX   = {1'b0, {(RPM_W-1){1'b1}}};
   localparam logic signed [RPM_W-1:0]   RPM_MIN   = {1'b1, {(RPM_W-1){1'b0}}};

   // {A,B} values in forward rotation order
   localparam logic [1:0] AB_S0 = 2'b00;
   localparam logic [1:0] AB_S1 = 2'b10;
   localparam logic [1:0] AB_S2 = 2'b11;
   localparam logic [1:0] AB_S3 = 2'b01;

   typedef enum logic [1:0] {
      TR_NONE,
      TR_FWD,
      TR_REV,
      TR_ILLEGAL
   } transition_t;

   function automatic logic [1:0] ab_phase(input logic [1:0] ab);
      case (ab)
         AB_S0:   return 2'd0;
         AB_S1:   return 2'd1;
         AB_S2:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   // Phase difference modulo 4: +1 forward, -1 reverse, 2 means both bits flipped.
   function automatic transition_t classify(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
      logic [1:0] diff;
      diff = ab_phase(cur_ab) - ab_phase(prev_ab);
      case (diff)
         2'd0:    return TR_NONE;
         2'd1:    return TR_FWD;
         2'd3:    return TR_REV;
         default: return TR_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature front end: per-channel synchronizer, optional glitch filter (ENC_GLITCH_FILTER_EN),
// 4x step decode and sticky illegal-transition flag.
module quad_decoder
   import encoder_pkg::*;
#(
   parameter int FILTER_CYCLES = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              enc_a,
   input  logic              enc_b,
   input  logic              error_clear,
   output logic signed [1:0] step,
   output logic              quad_error
);

   logic [1:0]  raw_ab;
   logic [1:0]  ab_cur;
   logic [1:0]  ab_prev_reg;
   logic        primed_reg;
   logic        illegal;
   transition_t tr_kind;

   assign raw_ab = {enc_a, enc_b};

`ifdef ENC_GLITCH_FILTER_EN
   localparam int FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else begin
               meta_reg <= raw_ab[gi];
               sync_reg <= meta_reg;
            end
         end

`ifdef ENC_GLITCH_FILTER_EN
         logic [FCNT_W-1:0] stable_cnt_reg;
         logic              filt_reg;

         // Count consecutive samples that disagree with the filtered value; any agreeing sample restarts.
         always_ff @(posedge clk) begin
            if (reset) begin
               stable_cnt_reg <= '0;
               filt_reg       <= 1'b0;
            end else if (sync_reg == filt_reg) begin
               stable_cnt_reg <= '0;
            end else if (stable_cnt_reg == FCNT_W'(FILTER_CYCLES - 1)) begin
               stable_cnt_reg <= '0;
               filt_reg       <= sync_reg;
            end else begin
               stable_cnt_reg <= stable_cnt_reg + FCNT_W'(1);
            end
         end
         assign ab_cur[gi] = filt_reg;
`else
         assign ab_cur[gi] = sync_reg;
`endif
      end
   endgenerate

   always_comb begin
      tr_kind = classify(ab_prev_reg, ab_cur);
      step    = 2'sd0;
      illegal = 1'b0;
      if (primed_reg) begin
         case (tr_kind)
            TR_FWD:     step = 2'sd1;
            TR_REV:     step = -2'sd1;
            TR_ILLEGAL: illegal = 1'b1;
            default:    step = 2'sd0;
         endcase
      end
   end

   // The first post-reset cycle only loads the previous pair; a new error wins over a clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ab_prev_reg <= 2'b00;
         primed_reg  <= 1'b0;
         quad_error  <= 1'b0;
      end else begin
         ab_prev_reg <= ab_cur;
         primed_reg  <= 1'b1;
         if (illegal)
            quad_error <= 1'b1;
         else if (error_clear)
            quad_error <= 1'b0;
      end
   end

endmodule

// File: rtl/encoder_rpm_meter.sv
// Windowed quadrature edge counter scaled to signed RPM; optional input glitch filter
// is selected with the ENC_GLITCH_FILTER_EN macro.
module encoder_rpm_meter
   import encoder_pkg::*;
#(
   parameter int unsigned WINDOW_CYCLES = 500000,
   parameter int unsigned RPM_MULT      = 3,
   parameter int unsigned RPM_SHIFT     = 1,
   parameter int          FILTER_CYCLES = 4
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ENC_A,
   input  logic                    ENC_B,
   input  logic                    enable,
   input  logic                    error_clear,
   output logic signed [RPM_W-1:0] RPM_Medidas,
   output logic                    rpm_valid,
   output logic                    dir_fwd,
   output logic                    quad_error
);

   localparam int CNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic signed [PROD_W-1:0] MULT_S = $signed({1'b0, (PROD_W-1)'(RPM_MULT)});

   logic signed [1:0]         step;
   logic [CNT_W-1:0]          win_cnt_reg;
   logic signed [DELTA_W-1:0] acc_reg;
   logic signed [DELTA_W:0]   acc_wide;
   logic signed [DELTA_W-1:0] acc_next;
   logic signed [PROD_W-1:0]  product;
   logic signed [PROD_W-1:0]  shifted;
   logic signed [RPM_W-1:0]   rpm_next;
   logic                      win_end;

   quad_decoder #(
      .FILTER_CYCLES(FILTER_CYCLES)
   ) u_quad_decoder (
      .clk        (clk),
      .reset      (reset),
      .enc_a      (ENC_A),
      .enc_b      (ENC_B),
      .error_clear(error_clear),
      .step       (step),
      .quad_error (quad_error)
   );

   assign win_end  = enable && (win_cnt_reg == CNT_W'(WINDOW_CYCLES - 1));
   assign acc_wide = (DELTA_W+1)'(acc_reg) + (DELTA_W+1)'(step);

   always_comb begin
      acc_next = acc_wide[DELTA_W-1:0];
      if (acc_wide > (DELTA_W+1)'(DELTA_MAX))
         acc_next = DELTA_MAX;
      else if (acc_wide < (DELTA_W+1)'(DELTA_MIN))
         acc_next = DELTA_MIN;
   end

   // Arithmetic shift of a signed product floors toward minus infinity.
   always_comb begin
      product  = PROD_W'(acc_reg) * MULT_S;
      shifted  = product >>> RPM_SHIFT;
      rpm_next = shifted[RPM_W-1:0];
      if (shifted > PROD_W'(RPM_MAX))
         rpm_next = RPM_MAX;
      else if (shifted < PROD_W'(RPM_MIN))
         rpm_next = RPM_MIN;
   end

   // At window end the finished count is converted and the step seen that cycle opens the next window.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt_reg <= '0;
         acc_reg     <= '0;
         RPM_Medidas <= '0;
         rpm_valid   <= 1'b0;
         dir_fwd     <= 1'b1;
      end else begin
         rpm_valid <= 1'b0;
         if (!enable) begin
            win_cnt_reg <= '0;
            acc_reg     <= '0;
         end else if (win_end) begin
            win_cnt_reg <= '0;
            acc_reg     <= DELTA_W'(step);
            RPM_Medidas <= rpm_next;
            dir_fwd     <= ~acc_reg[DELTA_W-1];
            rpm_valid   <= 1'b1;
         end else begin
            win_cnt_reg <= win_cnt_reg + CNT_W'(1);
            acc_reg     <= acc_next;
         end
      end
   end

endmodule

// File: tb/tb_encoder_rpm_meter.sv
// Self-checking bench: two meters (default scale and saturating scale) share one encoder stimulus.
module tb_encoder_rpm_meter;

   localparam int W = 100;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enc_a = 1'b0;
   logic enc_b = 1'b0;
   logic enable = 1'b0;
   logic error_clear = 1'b0;

   logic signed [15:0] rpm1, rpm2;
   logic valid1, valid2, dir1, dir2, qerr1, qerr2;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int pos = 0;
   int plan [0:599];
   int got_rpm [0:7];
   int got_sat [0:7];
   int got_dir [0:7];

   typedef struct {
      string name;
      int    steps;
      int    spacing;
      int    dir;
      int    exp_rpm;
      int    exp_sat;
      int    exp_dir;
   } vec_t;

   vec_t vecs [0:4];

   always #5 clk = ~clk;

   encoder_rpm_meter #(
      .WINDOW_CYCLES(W), .RPM_MULT(3), .RPM_SHIFT(1), .FILTER_CYCLES(4)
   ) u_dut (
      .clk(clk), .reset(reset), .ENC_A(enc_a), .ENC_B(enc_b), .enable(enable),
      .error_clear(error_clear), .RPM_Medidas(rpm1), .rpm_valid(valid1),
      .dir_fwd(dir1), .quad_error(qerr1)
   );

   encoder_rpm_meter #(
      .WINDOW_CYCLES(W), .RPM_MULT(1000), .RPM_SHIFT(0), .FILTER_CYCLES(4)
   ) u_sat (
      .clk(clk), .reset(reset), .ENC_A(enc_a), .ENC_B(enc_b), .enable(enable),
      .error_clear(error_clear), .RPM_Medidas(rpm2), .rpm_valid(valid2),
      .dir_fwd(dir2), .quad_error(qerr2)
   );

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic drive_pos();
      case (pos & 3)
         0:       {enc_a, enc_b} = 2'b00;
         1:       {enc_a, enc_b} = 2'b10;
         2:       {enc_a, enc_b} = 2'b11;
         default: {enc_a, enc_b} = 2'b01;
      endcase
   endtask

   // floor(d*m / 2^s), clamped to the 16-bit signed range
   function automatic int conv(input int d, input int m, input int s);
      longint p, q, div;
      p = longint'(d) * longint'(m);
      div = longint'(1) << s;
      if (p >= 0) q = p / div;
      else        q = -((-p + div - 1) / div);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   task automatic clear_plan();
      for (int i = 0; i < 600; i++) plan[i] = 0;
   endtask

   // Enable, play plan[] one entry per cycle for nwin windows, check every cycle, then disable.
   // A step driven at relative cycle c is decoded in window cycle c+2 and belongs to window (c+3)/W.
   task automatic run_test(input string name, input int nwin);
      int wsum [0:7];
      int n, w;
      for (int i = 0; i < 8; i++) wsum[i] = 0;
      enable = 1'b1;
      for (int c = 0; c < nwin * W; c++) begin
         if (plan[c] == 1 || plan[c] == -1) begin
            pos += plan[c];
            drive_pos();
            w = (c + 3) / W;
            if (w < nwin) wsum[w] += plan[c];
         end else if (plan[c] == 2) begin
            pos += 2;
            drive_pos();
         end
         tick();
         if ((c + 1) % W == 0) begin
            n = (c + 1) / W - 1;
            check({name, " valid"}, int'(valid1), 1);
            check({name, " sat valid"}, int'(valid2), 1);
            check({name, " rpm"}, int'(rpm1), conv(wsum[n], 3, 1));
            check({name, " sat rpm"}, int'(rpm2), conv(wsum[n], 1000, 0));
            check({name, " dir"}, int'(dir1), (wsum[n] >= 0) ? 1 : 0);
            got_rpm[n] = int'(rpm1);
            got_sat[n] = int'(rpm2);
            got_dir[n] = int'(dir1);
            $display("window %s #%0d: delta=%0d rpm=%0d sat_rpm=%0d dir=%0d", name, n, wsum[n],
                     int'(rpm1), int'(rpm2), int'(dir1));
         end else begin
            check({name, " no valid"}, int'(valid1 | valid2), 0);
         end
      end
      enable = 1'b0;
      clear_plan();
      repeat (4) tick();
   endtask

   initial begin
      vecs[0] = '{"fwd25", 25, 4,  1,     37,  25000, 1};
      vecs[1] = '{"rev25", 25, 4, -1,    -38, -25000, 0};
      vecs[2] = '{"fwd40", 40, 2,  1,     60,  32767, 1};
      vecs[3] = '{"rev40", 40, 2, -1,    -60, -32768, 0};
      vecs[4] = '{"idle",   0, 4,  1,      0,      0, 1};
      clear_plan();
      drive_pos();

      repeat (3) tick();
      check("reset rpm", int'(rpm1), 0);
      check("reset valid", int'(valid1), 0);
      check("reset dir", int'(dir1), 1);
      check("reset qerr", int'(qerr1), 0);
      check("reset sat rpm", int'(rpm2), 0);
      reset = 1'b0;
      repeat (4) tick();

      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < vecs[v].steps; k++) plan[k * vecs[v].spacing] = vecs[v].dir;
         run_test(vecs[v].name, 1);
         check({vecs[v].name, " table rpm"}, got_rpm[0], vecs[v].exp_rpm);
         check({vecs[v].name, " table sat"}, got_sat[0], vecs[v].exp_sat);
         check({vecs[v].name, " table dir"}, got_dir[0], vecs[v].exp_dir);
         check({vecs[v].name, " qerr"}, int'(qerr1), 0);
      end

      // Steps decoded on window cycles 98 and 99: the second lands in the next window.
      plan[96] = 1;
      plan[97] = 1;
      plan[110] = 1;
      run_test("boundary", 2);
      check("boundary win0", got_rpm[0], 1);
      check("boundary win1", got_rpm[1], 3);
      check("boundary sum", got_sat[0] + got_sat[1], 3000);

      // Both-bit jump: no count, sticky flag, cleared by a pulse.
      plan[10] = 1;
      plan[20] = 2;
      plan[30] = 1;
      run_test("illegal", 1);
      check("illegal count", got_rpm[0], 3);
      check("illegal qerr", int'(qerr1), 1);
      check("illegal sat qerr", int'(qerr2), 1);
      error_clear = 1'b1;
      tick();
      error_clear = 1'b0;
      check("qerr cleared", int'(qerr1), 0);

      // Clear coinciding with a new illegal transition leaves the flag set.
      pos += 2;
      drive_pos();
      tick();
      tick();
      error_clear = 1'b1;
      tick();
      error_clear = 1'b0;
      check("clear vs error", int'(qerr1), 1);
      tick();
      check("clear vs error hold", int'(qerr1), 1);
      error_clear = 1'b1;
      tick();
      error_clear = 1'b0;
      check("qerr cleared again", int'(qerr1), 0);

      // Random legal stimulus over three windows.
      for (int c = 0; c < 3 * W; c++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: plan[c] = 1;
            3, 4:    plan[c] = -1;
            default: plan[c] = 0;
         endcase
      end
      run_test("random", 3);
      check("random qerr", int'(qerr1), 0);

      // Reset at cycle 50 of a window holding 10 steps.
      while ((pos & 3) != 2) begin
         pos++;
         drive_pos();
         tick();
      end
      repeat (4) tick();
      enable = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (c % 4 == 0 && c < 40) begin
            pos++;
            drive_pos();
         end
         tick();
         check("pre-reset no valid", int'(valid1), 0);
      end
      reset = 1'b1;
      tick();
      check("midreset rpm", int'(rpm1), 0);
      check("midreset valid", int'(valid1), 0);
      check("midreset dir", int'(dir1), 1);
      check("midreset qerr", int'(qerr1), 0);
      reset = 1'b0;
      enable = 1'b0;
      tick();
      check("post-reset no valid", int'(valid1), 0);
      repeat (3) tick();
      for (int k = 0; k < 7; k++) plan[5 + k * 6] = 1;
      run_test("after reset", 1);
      check("after reset rpm", got_rpm[0], 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/encoder_rpm_meter.md
ENCODER_RPM_METER -- requirements
Module: encoder_rpm_meter

Interface
REQ-001 Parameter WINDOW_CYCLES, default 500000, sample window length in clk cycles (10 ms at 50 MHz).
REQ-002 Parameter RPM_MULT, default 3, unsigned scale multiplier from window count to RPM.
REQ-003 Parameter RPM_SHIFT, default 1, arithmetic right shift applied after RPM_MULT.
REQ-004 Parameter FILTER_CYCLES, default 4, stable-cycle count for the glitch filter.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ENC_A  in  1  encoder channel A, asynchronous.
REQ-008 ENC_B  in  1  encoder channel B, asynchronous.
REQ-009 enable  in  1  measurement enable.
REQ-010 error_clear  in  1  one-cycle pulse that clears quad_error.
REQ-011 RPM_Medidas  out  16  signed measured RPM, the feedback input of the PID stage.
REQ-012 rpm_valid  out  1  one-cycle pulse when RPM_Medidas updates.
REQ-013 dir_fwd  out  1  1 when the last completed window had a count of 0 or more.
REQ-014 quad_error  out  1  sticky illegal-transition flag.

Function
REQ-015 ENC_A/ENC_B SHALL pass through a 2-flop synchronizer before any use.
REQ-016 The decoder SHALL compare the current synchronized (filtered) AB pair with the previous pair every cycle, using 4x decoding.
REQ-017 The forward sequence SHALL be AB 00->10->11->01->00, counting +1 per step; the reverse sequence SHALL count -1 per step.
REQ-018 A cycle with no change SHALL count 0.
REQ-019 A change of both bits in one cycle SHALL count 0 and set quad_error, which stays set until error_clear or reset.
REQ-020 If error_clear and a new illegal transition coincide, quad_error SHALL end the cycle set.
REQ-021 Window counter: 0..WINDOW_CYCLES-1 with wrap; the wrap cycle is window end.
REQ-022 Delta accumulator: signed 20-bit, saturating at +524287/-524288, never wrapping.
REQ-023 At window end the accumulator SHALL be captured and reloaded with that cycle's step (0 or +/-1), so an edge on the boundary cycle counts in the new window.
REQ-024 Conversion of the captured delta: a 36-bit signed product delta*RPM_MULT, arithmetic-shifted right by RPM_SHIFT (floor toward minus infinity), then saturated to +32767/-32768.
REQ-025 RPM_Medidas and dir_fwd SHALL update exactly 1 cycle after window end (registered conversion), and rpm_valid SHALL pulse in that same cycle.
REQ-026 enable low SHALL: hold the window counter and accumulator at 0, hold RPM_Medidas/dir_fwd, and suppress rpm_valid, while synchronizer and quad_error keep running.
REQ-027 On enable rising, the first window SHALL be a full WINDOW_CYCLES long.

Reset
REQ-028 Reset SHALL clear synchronizers, filter, previous-AB register, counters and accumulator, RPM_Medidas=0, rpm_valid=0, dir_fwd=1 and quad_error=0.
REQ-029 The previous-AB register SHALL load the current AB on the first post-reset cycle without counting.
REQ-030 Reset mid-window SHALL discard the partial count, with no rpm_valid.

Configuration
REQ-031 Macro ENC_GLITCH_FILTER_EN defined: each channel updates its filtered value only after FILTER_CYCLES consecutive equal synchronized samples, adding FILTER_CYCLES cycles of edge latency.
REQ-032 Macro ENC_GLITCH_FILTER_EN undefined: the synchronized samples go directly to the decoder, and FILTER_CYCLES is ignored.

Structure
REQ-033 A shared package encoder_pkg SHALL hold the delta width (20), RPM width (16), product width (36), saturation limits, and the AB state encoding constants.
REQ-034 One sub-module, quad_decoder, SHALL own the synchronizer, optional filter, previous-AB register, step output (-1/0/+1) and illegal flag, while window/scale logic stays in the top.

Verification
REQ-035 WINDOW_CYCLES=100, 25 forward steps spaced 4 cycles, defaults for mult/shift -> RPM_Medidas=37 (25*3>>1), dir_fwd=1, one rpm_valid per window.
REQ-036 Same setup, 25 reverse steps -> RPM_Medidas=-38 (floor), dir_fwd=0.
REQ-037 AB jumps 00->11 -> quad_error=1, count unchanged, quad_error clears after an error_clear pulse.
REQ-038 RPM_MULT=1000, RPM_SHIFT=0, 40 forward steps -> RPM_Medidas=32767 saturated.
REQ-039 Edge on the window-end cycle -> it counts in the next window, with both windows' totals summing to the stimulus count.
REQ-040 Reset asserted at cycle 50 of a window with 10 steps taken -> no rpm_valid, outputs at reset values, and the next window counts only post-reset steps.
